// File: rtl/reservoir_readout.sv
// reservoir_readout
//   Linear readout for a spiking reservoir. It counts the spikes on each
//   neuron lane over a window of WIN enabled cycles. At window close it
//   snapshots the counts and runs a serial multiply-accumulate with the
//   programmable signed weights. The result is scaled by 1/WIN and clamped
//   to an unsigned Q6.10 prediction.
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   en        count enable; window counting pauses while low
//   spikes    one-cycle spike flags, neuron k on bit k
//   w_we      weight write strobe
//   w_addr    weight index (writes with w_addr >= N are ignored)
//   w_data    signed Q6.10 weight
//   y_hat     readout prediction, unsigned Q6.10, held between updates
//   y_valid   one-cycle pulse when y_hat is updated
//   win_done  one-cycle pulse at window close
module reservoir_readout #(
  parameter int N   = 10,
  parameter int WIN = 32,
  parameter int CW  = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] spikes,
  input  logic         w_we,
  input  logic [3:0]   w_addr,
  input  logic [15:0]  w_data,
  output logic [15:0]  y_hat,
  output logic         y_valid,
  output logic         win_done
);

  localparam int WW = $clog2(WIN);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_COUNT = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  logic [1:0]          state;
  logic [WW-1:0]       wcnt;
  logic [CW-1:0]       cnt    [N];
  logic [CW-1:0]       snap   [N];
  logic signed [15:0]  weight [N];
  logic [IW-1:0]       idx;
  logic signed [25:0]  acc;
  logic signed [25:0]  prod;
  logic signed [25:0]  y_sh;
  logic [15:0]         y_sat;
  logic                win_close;

  // WIN is a power of two, so the last window slot is the all-ones count.
  assign win_close = en && (wcnt == '1);

  always_comb begin
    // The count is zero-extended to make it non-negative before the signed multiply.
    prod = 26'($signed({1'b0, snap[idx]})) * 26'(weight[idx]);
    y_sh = acc >>> WW;
    if (y_sh < 0)
      y_sat = '0;
    else if (y_sh > 26'sd65535)
      y_sat = '1;
    else
      y_sat = y_sh[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_COUNT;
      wcnt     <= '0;
      idx      <= '0;
      acc      <= '0;
      y_hat    <= '0;
      y_valid  <= 1'b0;
      win_done <= 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        cnt[k]    <= '0;
        snap[k]   <= '0;
        weight[k] <= '0;
      end
    end else begin
      y_valid  <= 1'b0;
      win_done <= win_close;

      if (w_we && (32'(w_addr) < N))
        weight[w_addr] <= w_data;

      if (en)
        wcnt <= wcnt + WW'(1);

      // Counting runs in every state. The closing cycle's spike goes into the snapshot.
      for (int unsigned k = 0; k < N; k++) begin
        if (win_close) begin
          snap[k] <= cnt[k] + CW'(spikes[k]);
          cnt[k]  <= '0;
        end else if (en && spikes[k]) begin
          cnt[k] <= cnt[k] + CW'(1);
        end
      end

      case (state)
        S_COUNT: begin
          if (win_close) begin
            state <= S_MAC;
            idx   <= '0;
            acc   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod;
          if (idx == IW'(N - 1))
            state <= S_OUT;
          else
            idx <= idx + IW'(1);
        end
        S_OUT: begin
          y_hat   <= y_sat;
          y_valid <= 1'b1;
          state   <= S_COUNT;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_reservoir_readout.sv
// tb_reservoir_readout
//   Directed scoreboard bench for reservoir_readout. The stimulus pushes
//   hand-computed y_hat values into a queue. A negedge monitor pops the queue
//   and compares on every y_valid. The monitor also checks the window length
//   in enabled cycles and the win_done to y_valid latency.
module tb_reservoir_readout;
  localparam int N   = 10;
  localparam int WIN = 32;
  localparam int CW  = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] spikes;
  logic         w_we;
  logic [3:0]   w_addr;
  logic [15:0]  w_data;
  logic [15:0]  y_hat;
  logic         y_valid;
  logic         win_done;

  int           errors = 0;
  int           checks = 0;
  logic [15:0]  exp_q [$];
  logic [15:0]  e;
  int           cyc    = 0;
  int           wd_cyc = -1;
  int           en_cnt = 0;

  reservoir_readout #(.N(N), .WIN(WIN), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .spikes   (spikes),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .y_hat    (y_hat),
    .y_valid  (y_valid),
    .win_done (win_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, req, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      en_cnt = 0;
      wd_cyc = -1;
    end else begin
      if (win_done) begin
        check("win_len_en_cycles", en_cnt, WIN);
        en_cnt = 0;
        wd_cyc = cyc;
      end
      if (y_valid) begin
        check("y_valid_latency", cyc - wd_cyc, N + 1);
        if (exp_q.size() == 0) begin
          check("unexpected_y_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("y_hat", int'(y_hat), int'(e));
        end
      end
      en_cnt += int'(en);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    en     = 1'b0;
    spikes = '0;
    w_we   = 1'b0;
    w_addr = '0;
    w_data = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    w_we   = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_we   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    en     = 1'b0;
    spikes = '0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_y_hat", int'(y_hat), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_win_done", int'(win_done), 0);

    // Zero weights and random spikes over two back-to-back windows.
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    for (int c = 0; c < 2 * WIN; c++) begin
      en     = 1'b1;
      spikes = N'($urandom);
      tick();
    end
    drain();

    // Weight 1.0 on lane 0, which spikes every cycle: 32 * 1024 / 32 gives 0x0400.
    do_reset();
    wr(4'd0, 16'h0400);
    exp_q.push_back(16'h0400);
    for (int c = 0; c < WIN; c++) begin
      en     = 1'b1;
      spikes = N'(1);
      tick();
    end
    drain();

    // All weights 0x7FFF, all lanes spiking: the result saturates high.
    do_reset();
    for (int a = 0; a < N; a++) wr(4'(a), 16'h7FFF);
    exp_q.push_back(16'hFFFF);
    for (int c = 0; c < WIN; c++) begin
      en     = 1'b1;
      spikes = '1;
      tick();
    end
    drain();

    // Weight -1.0 on lane 3: the negative result clamps to zero.
    do_reset();
    wr(4'd3, 16'hFC00);
    exp_q.push_back(16'h0000);
    for (int c = 0; c < WIN; c++) begin
      en     = 1'b1;
      spikes = N'(8);
      tick();
    end
    drain();

    // Lane 4 weight 3.0 with 8 spikes ending on the closing cycle.
    // Lane 5 weight -0.5 spikes every cycle.
    // (8*3072 - 32*512) / 32 = 256 = 0x0100.
    do_reset();
    wr(4'd4, 16'h0C00);
    wr(4'd5, 16'hFE00);
    exp_q.push_back(16'h0100);
    for (int c = 0; c < WIN; c++) begin
      en        = 1'b1;
      spikes    = '0;
      spikes[5] = 1'b1;
      spikes[4] = (c >= WIN - 8);
      tick();
    end
    drain();

    // 16-cycle enable gap mid-window. Spikes during the gap must not be counted.
    do_reset();
    wr(4'd1, 16'h0400);
    exp_q.push_back(16'h0400);
    for (int c = 0; c < 16; c++) begin
      en = 1'b1; spikes = N'(2); tick();
    end
    for (int c = 0; c < 16; c++) begin
      en = 1'b0; spikes = '1; tick();
    end
    for (int c = 0; c < 16; c++) begin
      en = 1'b1; spikes = N'(2); tick();
    end
    drain();

    // Out-of-range weight writes must leave every weight untouched.
    do_reset();
    wr(4'd0, 16'h0400);
    wr(4'd12, 16'h1234);
    wr(4'd15, 16'h1234);
    wr(4'd10, 16'h1234);
    exp_q.push_back(16'h0400);
    for (int c = 0; c < WIN; c++) begin
      en     = 1'b1;
      spikes = '1;
      tick();
    end
    drain();

    // Reset in the middle of the MAC: no y_valid, and y_hat returns to 0.
    // The window completes on weights left from the previous test, so no result is queued.
    for (int c = 0; c < WIN + 3; c++) begin
      en     = 1'b1;
      spikes = N'(1);
      tick();
    end
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("mac_abort_y_hat", int'(y_hat), 0);
    check("mac_abort_y_valid", int'(y_valid), 0);
    en = 1'b0;
    spikes = '0;
    repeat (20) tick();
    // Counters and weights were cleared, so a fresh window must give exactly 0x0400.
    wr(4'd0, 16'h0400);
    exp_q.push_back(16'h0400);
    for (int c = 0; c < WIN; c++) begin
      en     = 1'b1;
      spikes = N'(1);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reservoir_readout.md
RESERVOIR_READOUT -- requirements
Module: reservoir_readout

Interface
REQ-001 Parameter N, default 10, number of reservoir neurons (spike lanes).
REQ-002 Parameter WIN, default 32, counting window length in enabled cycles; SHALL be a power of two and greater than N+1.
REQ-003 Parameter CW, default 6, spike-count width; SHALL hold WIN without overflow.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 en  input  1  count enable; when low, window counting pauses.
REQ-007 spikes  input  N  one-cycle spike flags from the neuron ring (i_out of neuron k on bit k).
REQ-008 w_we  input  1  weight write strobe.
REQ-009 w_addr  input  4  weight index.
REQ-010 w_data  input  16  signed weight, Q6.10.
REQ-011 y_hat  output  16  readout prediction, unsigned Q6.10 (same format as narma_output).
REQ-012 y_valid  output  1  one-cycle pulse: y_hat updated this cycle.
REQ-013 win_done  output  1  one-cycle pulse at window close.

Function
REQ-014 States: COUNT, MAC, OUT; counting of spikes continues in every state.
REQ-015 Per-neuron counter k increments by 1 on each cycle with en=1 and spikes[k]=1.
REQ-016 Window counter increments on en=1 cycles only, 0..WIN-1, and wraps to 0.
REQ-017 On the en=1 cycle with window counter = WIN-1: snapshot <= counter + spike of that cycle, counters cleared to 0, win_done=1, FSM to MAC.
REQ-018 MAC: N cycles, index i=0..N-1, acc += snapshot[i] * weight[i] (unsigned CW x signed 16, signed 26-bit acc); acc cleared at MAC entry.
REQ-019 MAC uses weight register value present in that cycle; writes land on the next edge.
REQ-020 After the last MAC cycle, FSM to OUT: y = acc >>> log2(WIN) (arithmetic); y<0 -> 0x0000; y>0xFFFF -> 0xFFFF; else y[15:0]; y_valid=1; FSM to COUNT.
REQ-021 Latency: y_valid asserted exactly N+1 cycles after the win_done cycle.
REQ-022 y_hat holds its value between y_valid pulses.
REQ-023 w_we=1 with w_addr<N writes weight[w_addr]; w_addr>=N ignored, no side effect.
REQ-024 en low during MAC/OUT does not stall the MAC sequence.
REQ-025 WIN>N+1 guarantees MAC completes before the next window closes; no overrun path required.

Reset
REQ-026 reset=0 on a rising edge: state COUNT, window counter 0, all spike counters 0, snapshot 0, acc 0, weights 0, y_hat 0x0000, y_valid 0, win_done 0.
REQ-027 Reset mid-MAC aborts the computation; no y_valid pulse for that window.
REQ-028 Weights SHALL be reloaded by the host after every reset.

Verification
REQ-029 Reset, weights all 0, random spikes, en=1 -> y_hat=0x0000, win_done every 32 cycles, y_valid 11 cycles after each win_done.
REQ-030 weight[0]=0x0400, spikes[0]=1 every cycle, others 0 -> count 32, acc 32768, y_hat=0x0400.
REQ-031 All weights 0x7FFF, all spikes 1 -> acc 10485440, shifted 327670 -> y_hat=0xFFFF saturated.
REQ-032 weight[3]=0xFC00 (-1.0), spikes[3]=1 always, others 0 -> y_hat=0x0000 clamped.
REQ-033 en=0 for 16 cycles mid-window -> win_done delayed by 16 cycles; spikes during en=0 not counted.
REQ-034 w_addr=12 write of 0x1234 -> all weights unchanged; reset asserted during MAC -> no y_valid, y_hat=0x0000, counters 0.
